// File: rtl/decode_stage.sv
// decode_stage: IF/ID pipeline register, 32x32 register file with write-through
// bypass, main control decoder and load-use hazard detection for a 5-stage MIPS core.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic [31:0] PC_in,
  input  logic        flush_in,
  input  logic        IDEX_MemRead_in,
  input  logic [4:0]  IDEX_rt_in,
  input  logic        WB_RegWrite_in,
  input  logic [4:0]  WB_addr_in,
  input  logic [31:0] WB_data_in,
  output logic        RegDst_out,
  output logic        ALUSrc_out,
  output logic        MemtoReg_out,
  output logic        RegWrite_out,
  output logic        MemRead_out,
  output logic        MemWrite_out,
  output logic        Branch_out,
  output logic [2:0]  ALUOp_out,
  output logic [31:0] PC_out,
  output logic [31:0] ReadData1_out,
  output logic [31:0] ReadData2_out,
  output logic [31:0] SignExtend_out,
  output logic [4:0]  rs_out,
  output logic [4:0]  rt_out,
  output logic [4:0]  rd_out,
  output logic        PCWrite_out,
  output logic [15:0] stall_count_out
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [2:0] alu_op;
  } ctrl_t;

  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_regs [32];
  logic [15:0] r_stall_count;

  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic        w_stall;
  logic        w_wb_en;
  ctrl_t       w_ctrl;
  ctrl_t       w_ctrl_out;

  assign w_rs    = r_ifid_instr[25:21];
  assign w_rt    = r_ifid_instr[20:16];
  assign w_wb_en = WB_RegWrite_in && (WB_addr_in != 5'd0);

  // Load-use hazard: the load in EX targets a register this instruction reads.
  assign w_stall = IDEX_MemRead_in && (IDEX_rt_in != 5'd0) &&
                   ((IDEX_rt_in == w_rs) || (IDEX_rt_in == w_rt));

  // IF/ID register: flush squashes to a NOP, a stall holds, otherwise load.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is always assigned with <= so every register samples pre-edge values.
    if (rst) begin
      r_ifid_instr <= '0;
      r_ifid_pc    <= '0;
    end else if (flush_in) begin
      r_ifid_instr <= '0;
      r_ifid_pc    <= '0;
    end else if (!w_stall) begin
      r_ifid_instr <= instr_in;
      r_ifid_pc    <= PC_in;
    end
  end

  // Register file write port; register 0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the register file is cleared on reset, so it must stay flops rather than a RAM macro.
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wb_en) begin
      r_regs[WB_addr_in] <= WB_data_in;
    end
  end

  // Saturating count of load-use stall cycles; a flushed cycle is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_stall && !flush_in && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  // Combinational read ports with write-through bypass from write-back.
  always_comb begin
    if (w_rs == 5'd0)                        ReadData1_out = '0;
    else if (w_wb_en && WB_addr_in == w_rs)  ReadData1_out = WB_data_in;
    else                                     ReadData1_out = r_regs[w_rs];
    if (w_rt == 5'd0)                        ReadData2_out = '0;
    else if (w_wb_en && WB_addr_in == w_rt)  ReadData2_out = WB_data_in;
    else                                     ReadData2_out = r_regs[w_rt];
  end

  // Main control decoder on the opcode field.
  always_comb begin
    // NOTE: default every field first so unlisted opcodes cannot infer latches.
    w_ctrl = '0;
    case (r_ifid_instr[31:26])
      OP_RTYPE: begin w_ctrl.reg_dst = 1'b1; w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = 3'b010; end
      OP_LW: begin
        w_ctrl.alu_src  = 1'b1; w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_write = 1'b1; w_ctrl.mem_read  = 1'b1;
      end
      OP_SW:   begin w_ctrl.alu_src = 1'b1; w_ctrl.mem_write = 1'b1; end
      OP_BEQ:  begin w_ctrl.branch  = 1'b1; w_ctrl.alu_op = 3'b001; end
      OP_ADDI: begin w_ctrl.alu_src = 1'b1; w_ctrl.reg_write = 1'b1; end
      OP_ANDI: begin w_ctrl.alu_src = 1'b1; w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = 3'b011; end
      OP_ORI:  begin w_ctrl.alu_src = 1'b1; w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = 3'b100; end
      OP_SLTI: begin w_ctrl.alu_src = 1'b1; w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = 3'b101; end
      default: w_ctrl = '0;
    endcase
  end

  // A stall inserts a bubble: all control lines to zero, data paths untouched.
  assign w_ctrl_out = w_stall ? '0 : w_ctrl;

  assign RegDst_out      = w_ctrl_out.reg_dst;
  assign ALUSrc_out      = w_ctrl_out.alu_src;
  assign MemtoReg_out    = w_ctrl_out.mem_to_reg;
  assign RegWrite_out    = w_ctrl_out.reg_write;
  assign MemRead_out     = w_ctrl_out.mem_read;
  assign MemWrite_out    = w_ctrl_out.mem_write;
  assign Branch_out      = w_ctrl_out.branch;
  assign ALUOp_out       = w_ctrl_out.alu_op;

  assign PC_out          = r_ifid_pc;
  assign SignExtend_out  = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};
  assign rs_out          = w_rs;
  assign rt_out          = w_rt;
  assign rd_out          = r_ifid_instr[15:11];
  assign PCWrite_out     = !w_stall;
  assign stall_count_out = r_stall_count;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a
// behavioural model of the IF/ID register, register file and hazard rules.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in, PC_in;
  logic        flush_in, IDEX_MemRead_in;
  logic [4:0]  IDEX_rt_in;
  logic        WB_RegWrite_in;
  logic [4:0]  WB_addr_in;
  logic [31:0] WB_data_in;
  logic        RegDst_out, ALUSrc_out, MemtoReg_out, RegWrite_out;
  logic        MemRead_out, MemWrite_out, Branch_out;
  logic [2:0]  ALUOp_out;
  logic [31:0] PC_out, ReadData1_out, ReadData2_out, SignExtend_out;
  logic [4:0]  rs_out, rt_out, rd_out;
  logic        PCWrite_out;
  logic [15:0] stall_count_out;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [31:0] m_regs [32];
  logic [31:0] m_instr, m_pc;
  int          m_cnt;

  // Opcode table: {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp[2:0]}
  logic [5:0] tab_op   [9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h3F};
  logic [9:0] tab_ctrl [9] = '{10'b1001000_010, 10'b0111100_000, 10'b0100010_000,
                               10'b0000001_001, 10'b0101000_000, 10'b0101000_011,
                               10'b0101000_100, 10'b0101000_101, 10'b0000000_000};

  decode_stage dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .PC_in(PC_in), .flush_in(flush_in),
    .IDEX_MemRead_in(IDEX_MemRead_in), .IDEX_rt_in(IDEX_rt_in),
    .WB_RegWrite_in(WB_RegWrite_in), .WB_addr_in(WB_addr_in), .WB_data_in(WB_data_in),
    .RegDst_out(RegDst_out), .ALUSrc_out(ALUSrc_out), .MemtoReg_out(MemtoReg_out),
    .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
    .Branch_out(Branch_out), .ALUOp_out(ALUOp_out), .PC_out(PC_out),
    .ReadData1_out(ReadData1_out), .ReadData2_out(ReadData2_out),
    .SignExtend_out(SignExtend_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
    .PCWrite_out(PCWrite_out), .stall_count_out(stall_count_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ctrl_of(input logic [5:0] op);
    for (int i = 0; i < 8; i++) if (tab_op[i] == op) return tab_ctrl[i];
    return 10'd0;
  endfunction

  function automatic logic [9:0] obs_ctrl();
    return {RegDst_out, ALUSrc_out, MemtoReg_out, RegWrite_out, MemRead_out,
            MemWrite_out, Branch_out, ALUOp_out};
  endfunction

  function automatic logic m_stall();
    int rs = int'(m_instr[25:21]);
    int rt = int'(m_instr[20:16]);
    int lt = int'(IDEX_rt_in);
    return IDEX_MemRead_in && lt != 0 && (lt == rs || lt == rt);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (WB_RegWrite_in && WB_addr_in == a) return WB_data_in;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_instr = '0;
    m_pc    = '0;
    m_cnt   = 0;
  endtask

  // Compare every output against the model for the current cycle.
  task automatic compare();
    logic st;
    logic [31:0] imm;
    st  = m_stall();
    imm = m_instr[15] ? {16'hFFFF, m_instr[15:0]} : {16'h0000, m_instr[15:0]};
    check("ctrl",   {22'd0, obs_ctrl()}, st ? 32'd0 : {22'd0, ctrl_of(m_instr[31:26])});
    check("pc",     PC_out, m_pc);
    check("rd1",    ReadData1_out, m_read(m_instr[25:21]));
    check("rd2",    ReadData2_out, m_read(m_instr[20:16]));
    check("sext",   SignExtend_out, imm);
    check("fields", {17'd0, rs_out, rt_out, rd_out}, {17'd0, m_instr[25:11]});
    check("pcwr",   {31'd0, PCWrite_out}, {31'd0, !st});
    check("cnt",    {16'd0, stall_count_out}, m_cnt);
  endtask

  task automatic model_update();
    logic st;
    if (rst) begin model_reset(); return; end
    st = m_stall();
    if (WB_RegWrite_in && WB_addr_in != 0) m_regs[WB_addr_in] = WB_data_in;
    if (st && !flush_in && m_cnt < 65535) m_cnt++;
    if (flush_in) begin m_instr = 0; m_pc = 0; end
    else if (!st) begin m_instr = instr_in; m_pc = PC_in; end
  endtask

  // One cycle: inputs already driven at the falling edge.
  task automatic step();
    #1 compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush_in = 0; IDEX_MemRead_in = 0; IDEX_rt_in = 0;
    WB_RegWrite_in = 0; WB_addr_in = 0; WB_data_in = 0;
  endtask

  initial begin
    logic [15:0] cnt_save;
    logic [31:0] pc_save;
    rst = 1'b1; instr_in = 0; PC_in = 0;
    idle_inputs();
    model_reset();

    // Reset state: NOP decode
    @(negedge clk);
    #1;
    check("rst_ctrl", {22'd0, obs_ctrl()}, {22'd0, 10'b1001000_010});
    check("rst_pcwr", {31'd0, PCWrite_out}, 32'd1);
    check("rst_cnt",  {16'd0, stall_count_out}, 32'd0);
    compare();
    rst = 1'b0;

    // Write-back r5, then decode add r1,r5,r5
    instr_in = {6'd0, 5'd5, 5'd5, 5'd1, 5'd0, 6'h20}; PC_in = 32'h4;
    WB_RegWrite_in = 1; WB_addr_in = 5; WB_data_in = 32'hDEADBEEF;
    step();
    idle_inputs(); instr_in = {6'd0, 5'd0, 5'd0, 5'd3, 5'd0, 6'h20}; PC_in = 32'h8;
    #1;
    check("wb_rd1", ReadData1_out, 32'hDEADBEEF);
    check("wb_rd2", ReadData2_out, 32'hDEADBEEF);
    WB_RegWrite_in = 1; WB_addr_in = 0; WB_data_in = 32'hFFFFFFFF;
    step();
    #1 check("r0_rd1", ReadData1_out, 32'd0);
    idle_inputs();

    // Same-cycle bypass on rs=7
    instr_in = {6'h08, 5'd7, 5'd2, 16'h0010}; PC_in = 32'hC;
    step();
    WB_RegWrite_in = 1; WB_addr_in = 7; WB_data_in = 32'h12345678;
    #1 check("bypass", ReadData1_out, 32'h12345678);
    step();
    idle_inputs();

    // Load-use stall on rs=8
    instr_in = {6'd0, 5'd8, 5'd2, 5'd9, 5'd0, 6'h20}; PC_in = 32'h10;
    step();
    pc_save = PC_out; cnt_save = stall_count_out;
    instr_in = 32'h2002_0001; PC_in = 32'h14;
    IDEX_MemRead_in = 1; IDEX_rt_in = 8;
    #1;
    check("lu_pcwr", {31'd0, PCWrite_out}, 32'd0);
    check("lu_ctrl", {22'd0, obs_ctrl()}, 32'd0);
    step();
    check("lu_hold", PC_out, pc_save);
    check("lu_cnt",  {16'd0, stall_count_out}, {16'd0, cnt_save} + 32'd1);

    // Flush together with stall
    cnt_save = stall_count_out;
    flush_in = 1;
    #1 check("fl_pcwr", {31'd0, PCWrite_out}, 32'd0);
    step();
    check("fl_pc",  PC_out, 32'd0);
    check("fl_cnt", {16'd0, stall_count_out}, {16'd0, cnt_save});
    idle_inputs();

    // Decode table, negative immediate
    for (int i = 0; i < 9; i++) begin
      instr_in = {tab_op[i], 5'd1, 5'd2, 16'hFFF0}; PC_in = 32'h100 + 32'(i * 4);
      step();
      #1 check("decode", {22'd0, obs_ctrl()}, {22'd0, tab_ctrl[i]});
      if (i == 1) check("lw_sext", SignExtend_out, 32'hFFFFFFF0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r = $urandom;
      instr_in = (r[3:0] < 4'd12) ? {tab_op[r[7:4] % 9], 26'($urandom)} : $urandom;
      PC_in = $urandom;
      flush_in = ($urandom_range(0, 9) == 0);
      WB_RegWrite_in = $urandom_range(0, 1);
      WB_addr_in = (r[9:8] == 0) ? m_instr[25:21] : 5'($urandom);
      WB_data_in = $urandom;
      IDEX_MemRead_in = ($urandom_range(0, 2) == 0);
      case (r[11:10])
        2'd0: IDEX_rt_in = m_instr[25:21];
        2'd1: IDEX_rt_in = m_instr[20:16];
        default: IDEX_rt_in = 5'($urandom);
      endcase
      step();
    end
    idle_inputs();

    // Async reset between edges with populated registers
    instr_in = {6'd0, 5'd5, 5'd9, 5'd1, 5'd0, 6'h20}; PC_in = 32'h200;
    WB_RegWrite_in = 1; WB_addr_in = 9; WB_data_in = 32'hA5A5A5A5;
    step();
    idle_inputs();
    IDEX_MemRead_in = 1; IDEX_rt_in = 5;
    step();
    check("pre_rst_cnt_nz", {31'd0, stall_count_out != 0}, 32'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst_rd1", ReadData1_out, 32'd0);
    check("arst_rd2", ReadData2_out, 32'd0);
    check("arst_cnt", {16'd0, stall_count_out}, 32'd0);
    check("arst_pcwr", {31'd0, PCWrite_out}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    instr_in = {6'd0, 5'd5, 5'd9, 5'd1, 5'd0, 6'h20}; PC_in = 32'h300;
    step();
    #1;
    check("post_rst_rd1", ReadData1_out, 32'd0);
    check("post_rst_rd2", ReadData2_out, 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports instr_in  input  32  fetched instruction, and PC_in  input  32  PC+4 of that instruction.
REQ-004 SHALL have port flush_in  input  1  taken-branch squash of the IF/ID register.
REQ-005 SHALL have ports IDEX_MemRead_in  input  1  and IDEX_rt_in  input  5  from the ID/EX buffer outputs, for load-use detection.
REQ-006 SHALL have write-back ports WB_RegWrite_in  input  1,  WB_addr_in  input  5,  WB_data_in  input  32.
REQ-007 SHALL have control outputs RegDst_out, ALUSrc_out, MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out (output 1 each) and ALUOp_out (output 3), feeding ID/EX.
REQ-008 SHALL have data outputs PC_out 32, ReadData1_out 32, ReadData2_out 32, SignExtend_out 32, rs_out 5, rt_out 5, rd_out 5, feeding ID/EX.
REQ-009 SHALL have outputs PCWrite_out  1  PC update enable to fetch, and stall_count_out  16  saturating count of load-use stall cycles.

Function
REQ-010 SHALL hold an IF/ID register (instr, pc); on posedge: flush_in -> both cleared to 0 (NOP); else stall -> hold; else load instr_in/PC_in.
REQ-011 flush_in SHALL take priority over stall in the same cycle.
REQ-012 Decode outputs SHALL be combinational from the IF/ID register (one-cycle latency from instr_in to outputs).
REQ-013 rs_out=instr[25:21], rt_out=instr[20:16], rd_out=instr[15:11], PC_out=IF/ID pc, SignExtend_out={16{instr[15]},instr[15:0]}.
REQ-014 SHALL contain a 32x32 register file; write on posedge when WB_RegWrite_in=1 and WB_addr_in!=0; register 0 SHALL read 0 always.
REQ-015 Reads SHALL be combinational with write-through bypass: WB_RegWrite_in=1, WB_addr_in!=0 and WB_addr_in equals rs (rt) -> ReadData1_out (ReadData2_out) = WB_data_in.
REQ-016 Control decode by opcode instr[31:26], listing only the signals set to 1 (all others 0):
  000000 R-type: RegDst, RegWrite; ALUOp=010.
  100011 lw: ALUSrc, MemtoReg, RegWrite, MemRead; ALUOp=000.
  101011 sw: ALUSrc, MemWrite; ALUOp=000.
  000100 beq: Branch; ALUOp=001.
  001000 addi: ALUSrc, RegWrite; ALUOp=000.
  001100 andi: ALUSrc, RegWrite; ALUOp=011.
  001101 ori: ALUSrc, RegWrite; ALUOp=100.
  001010 slti: ALUSrc, RegWrite; ALUOp=101.
  Any other opcode: all control outputs 0.
REQ-017 stall SHALL = IDEX_MemRead_in AND IDEX_rt_in!=0 AND (IDEX_rt_in==rs OR IDEX_rt_in==rt).
REQ-018 While stall=1: PCWrite_out=0, IF/ID held, and all eight control outputs forced to 0 (bubble); data outputs are unaffected.
REQ-019 PCWrite_out SHALL = NOT stall, including while flush_in=1.
REQ-020 stall_count_out SHALL increment on each posedge where stall=1 and flush_in=0, and SHALL saturate at 16'hFFFF.
REQ-021 Simultaneous write-back and read of the same register SHALL return the new data in the same cycle, per REQ-015.

Reset
REQ-022 rst=1 SHALL immediately clear the IF/ID register, all 32 registers and stall_count_out to 0, independent of clk.
REQ-023 During and after reset, until the first load, outputs SHALL equal NOP decode: RegDst_out=1, RegWrite_out=1, ALUOp_out=010, ReadData*=0, PC_out=0, PCWrite_out=1.
REQ-024 rst asserted mid-stall SHALL drop stall, except that a stall driven purely by the IDEX inputs SHALL still apply per REQ-017.

Verification
REQ-025 Write-back: WB writes 0xDEADBEEF to r5; next cycle decode add r1,r5,r5 -> ReadData1_out=ReadData2_out=0xDEADBEEF; WB to r0 -> r0 reads 0.
REQ-026 Bypass: same-cycle WB r7=0x12345678 while decoding rs=7 -> ReadData1_out=0x12345678 in that cycle.
REQ-027 Load-use: IDEX_MemRead_in=1, IDEX_rt_in=8; decode rs=8 -> PCWrite_out=0, controls all 0, IF/ID holds one cycle, stall_count_out 0->1.
REQ-028 Flush vs stall: flush_in=1 together with a stall -> IF/ID becomes 0 next cycle, stall_count_out unchanged.
REQ-029 Decode table: drive each REQ-016 opcode plus 0x3F -> exact control vector per table; lw imm 0xFFF0 -> SignExtend_out=0xFFFFFFF0.
REQ-030 Async reset: assert rst between clock edges with a populated register file -> all reads 0 and stall_count_out=0 before the next edge.
